// File: rtl/timer_ctrl.sv
// Countdown timer controller: start/pause/cancel FSM driving a mod-10/mod-6 counter chain.
// Optional alarm output is built in when TIMER_CTRL_ALARM_EN is defined.
module timer_ctrl #(
  parameter int TICK_DIV    = 10,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic       zero,
  output logic       load,
  output logic       en,
  output logic [1:0] state,
  output logic       done
`ifdef TIMER_CTRL_ALARM_EN
  ,
  output logic       alarm
`endif
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  // Out-of-range parameters leave the controller unable to tick.
  localparam bit PARAMS_OK = (TICK_DIV >= 2) && (ALARM_TICKS >= 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          start_q, pause_q, cancel_q;
  logic          start_edge, pause_edge, cancel_edge;
  logic [PW-1:0] presc_q, presc_d;
  logic          presc_wrap;
  logic          en_q, en_d;

  assign start_edge  = start  & ~start_q;
  assign pause_edge  = pause  & ~pause_q;
  assign cancel_edge = cancel & ~cancel_q;
  assign presc_wrap  = (presc_q == PRESC_MAX);

`ifdef TIMER_CTRL_ALARM_EN
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  logic          alarm_q, alarm_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      cancel_q <= 1'b0;
      presc_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      pause_q  <= pause;
      cancel_q <= cancel;
      presc_q  <= presc_d;
      en_q     <= en_d;
    end
  end

  // Cancel outranks every other request, including a coincident start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge && !cancel_edge && !zero) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (cancel_edge)     state_d = S_IDLE;
        else if (pause_edge) state_d = S_PAUSED;
        else if (zero)       state_d = S_DONE;
      end
      S_PAUSED: begin
        if (cancel_edge)     state_d = S_IDLE;
        else if (start_edge) state_d = S_RUNNING;
      end
      S_DONE: begin
        if (start_edge || cancel_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The prescaler only advances on cycles that stay in RUNNING, so a pause
  // freezes it at the value it held when the pause edge arrived.
  always_comb begin
    presc_d = '0;
    en_d    = 1'b0;
    unique case (state_q)
      S_RUNNING: begin
        if (state_d == S_RUNNING) begin
          presc_d = presc_wrap ? '0 : presc_q + PW'(1);
          en_d    = PARAMS_OK && presc_wrap;
        end else if (state_d == S_PAUSED) begin
          presc_d = presc_q;
        end
      end
      S_PAUSED: begin
        if (state_d != S_IDLE) presc_d = presc_q;
      end
      S_DONE: begin
`ifdef TIMER_CTRL_ALARM_EN
        if (state_d == S_DONE && alarm_q) presc_d = presc_wrap ? '0 : presc_q + PW'(1);
`endif
      end
      default: presc_d = '0;
    endcase
  end

`ifdef TIMER_CTRL_ALARM_EN
  // Alarm rises on DONE entry and falls after ALARM_TICKS prescaler wraps.
  always_comb begin
    alarm_d     = 1'b0;
    alarm_cnt_d = '0;
    if (state_q != S_DONE && state_d == S_DONE) begin
      alarm_d = 1'b1;
    end else if (state_q == S_DONE && state_d == S_DONE && alarm_q) begin
      alarm_d     = 1'b1;
      alarm_cnt_d = alarm_cnt_q;
      if (presc_wrap) begin
        if (alarm_cnt_q == ALARM_LAST) begin
          alarm_d     = 1'b0;
          alarm_cnt_d = '0;
        end else begin
          alarm_cnt_d = alarm_cnt_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm = alarm_q;
`endif

  assign state = state_q;
  assign load  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign en    = en_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4, ALARM_TICKS=2.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       start, pause, cancel, zero;
  logic       load, en, done;
  logic [1:0] state_w;
`ifdef TIMER_CTRL_ALARM_EN
  logic       alarm;
`endif

  int errors = 0;
  int checks = 0;

  timer_ctrl #(
    .TICK_DIV    (4),
    .ALARM_TICKS (2)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .pause  (pause),
    .cancel (cancel),
    .zero   (zero),
    .load   (load),
    .en     (en),
    .state  (state_w),
    .done   (done)
`ifdef TIMER_CTRL_ALARM_EN
    ,
    .alarm  (alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       pause;
    logic       cancel;
    logic       zero;
    logic [1:0] st;
    logic       en;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic p, input logic c, input logic z,
                     input logic [1:0] st, input logic e);
    vec_t v;
    v.start = s; v.pause = p; v.cancel = c; v.zero = z; v.st = st; v.en = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ens;
    int busy;
    int acnt;
    logic [4:0] exp_v;

    clear = 1'b1; start = 1'b0; pause = 1'b0; cancel = 1'b0; zero = 1'b0;

    // start pause cancel zero | state en
    add(1,0,0,0, 1,0); add(1,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    add(0,0,0,0, 1,1); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    add(0,0,0,0, 1,1); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    add(0,0,0,0, 1,1); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    add(0,1,0,0, 2,0); add(0,1,0,0, 2,0); add(0,0,0,0, 2,0); add(0,1,0,0, 2,0);
    add(1,0,0,0, 1,0); add(1,0,0,0, 1,0); add(0,0,0,0, 1,1); add(0,0,0,0, 1,0);
    add(0,0,0,1, 3,0); add(0,0,0,1, 3,0); add(0,0,0,0, 3,0);
    add(1,0,0,0, 0,0); add(0,0,0,0, 0,0);
    add(1,0,0,1, 0,0); add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    add(1,0,1,0, 0,0); add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    add(0,0,0,1, 3,0); add(0,0,1,0, 0,0); add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,1,0,0, 2,0); add(0,0,0,0, 2,0);
    add(1,0,1,0, 0,0); add(0,0,0,0, 0,0);
    add(1,0,0,0, 1,0); add(0,0,0,0, 1,0); add(0,1,1,0, 0,0); add(0,0,0,0, 0,0);

    repeat (2) step();
    check("reset_state", state_w, 0);
    check("reset_load", load, 0);
    check("reset_en", en, 0);
    check("reset_done", done, 0);
    clear = 1'b0;
    step();
    check("release_state", state_w, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; pause = vecs[i].pause;
      cancel = vecs[i].cancel; zero = vecs[i].zero;
      step();
      exp_v = {vecs[i].st, vecs[i].st != 2'd0, vecs[i].en, vecs[i].st == 2'd3};
      $display("vec %0d: s=%0b p=%0b c=%0b z=%0b -> state=%0d load=%0b en=%0b done=%0b",
               i, start, pause, cancel, zero, state_w, load, en, done);
      check($sformatf("vec%0d", i), int'({state_w, load, en, done}), int'(exp_v));
    end
    start = 1'b0; pause = 1'b0; cancel = 1'b0; zero = 1'b0;
    step();

    // Asynchronous clear while en is high, then a clean restart.
    start = 1'b1; step(); start = 1'b0;
    check("clr_entry", state_w, 1);
    repeat (3) step();
    step();
    check("clr_en_before", en, 1);
    clear = 1'b1;
    #1;
    check("clr_en_async", en, 0);
    check("clr_state_async", state_w, 0);
    check("clr_load_async", load, 0);
    repeat (2) step();
    clear = 1'b0;
    ens = 0; busy = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      ens += int'(en);
      busy += int'(state_w != 2'd0);
    end
    check("clr_no_spurious_en", ens, 0);
    check("clr_stays_idle", busy, 0);
    $display("clear sequence: en_count=%0d busy_cycles=%0d", ens, busy);

    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("restart_no_early_en", en, 0);
    step();
    check("restart_first_en", en, 1);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("restart_cancel", state_w, 0);
    step();

    // Start held for 20 cycles: exactly one transition, four ticks.
    start = 1'b1;
    ens = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      ens += int'(en);
      check($sformatf("held_state%0d", k), state_w, 1);
    end
    check("held_en_count", ens, 4);
    $display("held start: en_count=%0d state=%0d", ens, state_w);
    start = 1'b0; cancel = 1'b1; step(); cancel = 1'b0;
    check("held_cancel", state_w, 0);
    step();

`ifdef TIMER_CTRL_ALARM_EN
    start = 1'b1; step(); start = 1'b0;
    zero = 1'b1; step(); zero = 1'b0;
    check("alarm_done_entry", state_w, 3);
    check("alarm_entry", alarm, 1);
    acnt = int'(alarm);
    for (int k = 0; k < 11; k++) begin
      step();
      acnt += int'(alarm);
    end
    check("alarm_len", acnt, 8);
    check("alarm_done_kept", done, 1);
    $display("alarm: high_cycles=%0d done=%0b", acnt, done);
    start = 1'b1; step(); start = 1'b0;
    check("alarm_idle_state", state_w, 0);
    check("alarm_idle_low", alarm, 0);
    step();
    start = 1'b1; step(); start = 1'b0;
    zero = 1'b1; step(); zero = 1'b0;
    check("alarm_entry2", alarm, 1);
    repeat (2) step();
    check("alarm_before_cancel", alarm, 1);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("alarm_cancel_low", alarm, 0);
    check("alarm_cancel_state", state_w, 0);
    step();
`else
    acnt = 0;
    check("final_idle_alarm_off", state_w + acnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
